// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared instruction-memory constants and loader state encoding
package imem_loader_pkg;

   localparam int MEM_CELL_SIZE  = 8;
   localparam int INSTR_MEM_SIZE = 1024;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time framed byte-stream writer for the instruction memory
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_SIZE = INSTR_MEM_SIZE,
   parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [MEM_CELL_SIZE-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [MEM_CELL_SIZE-1:0] mem_wdata,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     error
);

   state_t                     state;
   state_t                     state_next;
   logic [MEM_CELL_SIZE-1:0]   len_hi;
   logic [ADDR_W:0]            len;
   logic [ADDR_W:0]            idx;
   logic [MEM_CELL_SIZE-1:0]   csum;
   logic                       accept;
   logic                       start_ok;
   logic [15:0]                frame_len;
   logic                       len_bad;
   logic                       last_data;

   assign accept    = in_valid & in_ready;
   assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
   assign frame_len = {len_hi, in_data};
   // Odd lengths would split a 16-bit instruction across images.
   assign len_bad   = frame_len[0] | (32'(frame_len) > 32'(MEM_SIZE));
   assign last_data = (idx == (len - 1'b1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start_ok) state_next = S_LEN_HI;
         S_LEN_HI: if (accept)   state_next = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_bad)              state_next = S_ERROR;
               else if (frame_len == '0) state_next = S_CSUM;
               else                      state_next = S_DATA;
            end
         end
         S_DATA:   if (accept && last_data) state_next = S_CSUM;
         S_CSUM: begin
            if (accept) state_next = (in_data == csum) ? S_DONE : S_ERROR;
         end
         S_DONE, S_ERROR: if (start_ok) state_next = S_LEN_HI;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      cpu_hold = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: in_ready = 1'b1;
         S_DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
         end
         S_ERROR:  error = 1'b1;
         default:  ;
      endcase
   end

   // Write port is registered: a byte accepted in cycle t lands at the edge ending t+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi    <= '0;
         len       <= '0;
         idx       <= '0;
         csum      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (start_ok) begin
            idx  <= '0;
            csum <= '0;
         end
         if (accept) begin
            case (state)
               S_LEN_HI: len_hi <= in_data;
               S_LEN_LO: len    <= frame_len[ADDR_W:0];
               S_DATA: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= idx[ADDR_W-1:0];
                  mem_wdata <= in_data;
                  csum      <= csum ^ in_data;
                  idx       <= idx + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven directed bench for imem_loader
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int MS = INSTR_MEM_SIZE;
   localparam int AW = $clog2(MS);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;

   logic [7:0]    mem [0:MS-1];
   int            wr_cnt = 0;
   int            last_addr = -1;
   int            n_cmp = 0;
   int            n_bad = 0;

   typedef struct {
      int         n;
      logic [7:0] csum_x;
      bit         gap;
      bit         exp_done;
      bit         exp_err;
      int         exp_wr;
   } vec_t;

   vec_t vt [9];

   imem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Instruction-memory write port model
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] = mem_wdata;
         wr_cnt        = wr_cnt + 1;
         last_addr     = int'(mem_addr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pay(input int n, input int k);
      if (n == 4) begin
         case (k)
            0:       return 8'h06;
            1:       return 8'h20;
            2:       return 8'h31;
            default: return 8'h06;
         endcase
      end
      return 8'((k * 7 + 3) & 255);
   endfunction

   task automatic send(input logic [7:0] b, input bit gap);
      int t;
      if (gap) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready stayed 0 for byte %0h", b);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int         w0;
      int         bad_cells;
      logic [7:0] cs;
      bit         len_err;
      w0 = wr_cnt;
      len_err = (v.n % 2 == 1) || (v.n > MS);
      pulse_start();
      chk("busy_ready", 32'(in_ready), 32'd1);
      send(8'(v.n >> 8), v.gap);
      send(8'(v.n & 255), v.gap);
      if (!len_err) begin
         cs = 8'h00;
         for (int k = 0; k < v.n; k++) begin
            cs = cs ^ pay(v.n, k);
            send(pay(v.n, k), v.gap);
         end
         send(cs ^ v.csum_x, v.gap);
      end
      chk($sformatf("n%0d_done", v.n), 32'(done), 32'(v.exp_done));
      chk($sformatf("n%0d_error", v.n), 32'(error), 32'(v.exp_err));
      chk($sformatf("n%0d_cpu_hold", v.n), 32'(cpu_hold), 32'(!v.exp_done));
      chk($sformatf("n%0d_in_ready", v.n), 32'(in_ready), 32'd0);
      chk($sformatf("n%0d_writes", v.n), 32'(wr_cnt - w0), 32'(v.exp_wr));
      if (!len_err && v.n > 0) begin
         bad_cells = 0;
         for (int k = 0; k < v.n; k++)
            if (mem[k] !== pay(v.n, k)) bad_cells++;
         chk($sformatf("n%0d_cells_bad", v.n), 32'(bad_cells), 32'd0);
         chk($sformatf("n%0d_last_addr", v.n), 32'(last_addr), 32'(v.n - 1));
      end
      if (v.n == 4 && v.exp_done)
         chk("fetch0", {16'h0, mem[0], mem[1]}, 32'h0620);
      @(posedge clk); #1;
      chk($sformatf("n%0d_hold_status", v.n), {30'h0, done, error}, {30'h0, v.exp_done, v.exp_err});
      chk($sformatf("n%0d_ready_after", v.n), 32'(in_ready), 32'd0);
   endtask

   initial begin
      int w0;
      for (int i = 0; i < MS; i++) mem[i] = 8'h00;
      rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;

      vt[0] = '{n: 4,    csum_x: 8'h00, gap: 0, exp_done: 1, exp_err: 0, exp_wr: 4};
      vt[1] = '{n: 4,    csum_x: 8'h03, gap: 0, exp_done: 0, exp_err: 1, exp_wr: 4};
      vt[2] = '{n: 4,    csum_x: 8'h00, gap: 0, exp_done: 1, exp_err: 0, exp_wr: 4};
      vt[3] = '{n: 3,    csum_x: 8'h00, gap: 0, exp_done: 0, exp_err: 1, exp_wr: 0};
      vt[4] = '{n: 1026, csum_x: 8'h00, gap: 0, exp_done: 0, exp_err: 1, exp_wr: 0};
      vt[5] = '{n: 0,    csum_x: 8'h00, gap: 0, exp_done: 1, exp_err: 0, exp_wr: 0};
      vt[6] = '{n: 0,    csum_x: 8'h01, gap: 0, exp_done: 0, exp_err: 1, exp_wr: 0};
      vt[7] = '{n: 4,    csum_x: 8'h00, gap: 1, exp_done: 1, exp_err: 0, exp_wr: 4};
      vt[8] = '{n: 1024, csum_x: 8'h00, gap: 0, exp_done: 1, exp_err: 0, exp_wr: 1024};

      @(posedge clk); @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_status", {29'h0, cpu_hold, done, error}, 32'b100);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_vec(vt[i]);

      // Reset after two payload accepts; cell 1 write is in flight on the rst edge
      w0 = wr_cnt;
      pulse_start();
      send(8'h00, 0); send(8'h04, 0); send(8'h06, 0); send(8'h20, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst_mem_we", 32'(mem_we), 32'd0);
      chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("mrst_status", {28'h0, in_ready, cpu_hold, done, error}, 32'b0100);
      chk("mrst_cells", {mem[0], mem[1], mem[2], mem[3]}, 32'h06201118);
      chk("mrst_writes", 32'(wr_cnt - w0), 32'd2);
      rst = 1'b0;
      @(posedge clk); #1;
      run_vec(vt[0]);

      // rst and start together: rst wins, loader stays idle
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_start_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("rst_start_idle", {29'h0, in_ready, cpu_hold, done}, 32'b010);

      // start during S_DATA is ignored
      w0 = wr_cnt;
      pulse_start();
      send(8'h00, 0); send(8'h04, 0); send(8'h06, 0);
      chk("lat_we_addr_data", {15'h0, mem_we, 6'h0, mem_addr}, {15'h0, 1'b1, 16'h0000});
      chk("lat_wdata", 32'(mem_wdata), 32'h06);
      pulse_start();
      chk("busy_gap_no_write", 32'(mem_we), 32'd0);
      send(8'h20, 0); send(8'h31, 0); send(8'h06, 0); send(8'h11, 0);
      chk("busy_start_done", {29'h0, done, error, cpu_hold}, 32'b100);
      chk("busy_start_writes", 32'(wr_cnt - w0), 32'd4);
      chk("busy_start_cells", {mem[0], mem[1], mem[2], mem[3]}, 32'h06203106);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a framed byte stream over a valid/ready handshake, checks length and checksum, and writes each payload byte into consecutive 8-bit instruction-memory cells starting at cell 0. It holds the core in reset until a complete, valid image has been written. It sits between the host byte link and the instruction memory's write port; the fetch side continues to read 16-bit instructions as {cell[a], cell[a+1]}.

## Interface
- MEM_SIZE, default 1024: number of 8-bit instruction-memory cells; must be a power of two.
- ADDR_W, default $clog2(MEM_SIZE): cell address width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  cell address.
- mem_wdata  out  8  cell data.
- cpu_hold  out  1  holds the core in reset.
- done  out  1  a valid image is loaded.
- error  out  1  the last load failed.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit payload length N, big-endian), then N payload bytes, then one CSUM byte. CSUM is the XOR of all payload bytes (0x00 when N=0).
- Accept means in_valid & in_ready in the same cycle. in_ready is a pure function of state: high in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM; low elsewhere.
- States and transitions:
  - S_IDLE: start -> S_LEN_HI.
  - S_LEN_HI: accept -> S_LEN_LO.
  - S_LEN_LO: accept -> S_ERROR if N is odd or N > MEM_SIZE; -> S_CSUM if N=0; otherwise -> S_DATA.
  - S_DATA: on each accept, write the byte to cell idx, XOR it into csum, and increment idx. After the N-th accept -> S_CSUM.
  - S_CSUM: accept -> S_DONE if the byte equals csum, otherwise -> S_ERROR.
  - S_DONE and S_ERROR: start -> S_LEN_HI. On this transition idx, csum, done and error clear, and cpu_hold sets.
- start is ignored in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM.
- idx is ADDR_W+1 bits wide so that N = MEM_SIZE is representable. The write address is idx[ADDR_W-1:0]. Payload byte k is written to cell k, which makes the stream big-endian per 16-bit instruction.
- Cells beyond N are not written. The loader never clears memory, and partial writes from a failed or reset load are left in place.
- cpu_hold = 1 in every state except S_DONE.
- done = 1 only in S_DONE. error = 1 only in S_ERROR.

## Timing
- Reset values: state S_IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, idx 0, csum 0.
- Write latency: mem_we, mem_addr and mem_wdata are registered. A byte accepted in cycle t is written at the clock edge ending cycle t+1. mem_we is high for exactly one cycle per payload byte.
- Back-to-back accepts give one write per cycle. Gaps in in_valid insert no writes and lose no state.
- Final writes: the last payload write happens in the cycle after the last data accept, which overlaps the first S_CSUM cycle. done therefore never rises before the final write has completed.
- Status latency: done or error rises one cycle after the CSUM accept, or one cycle after the LEN_LO accept for a length error. cpu_hold falls in the same cycle that done rises.
- rst mid-load: the next cycle shows reset values. A pending mem_we is dropped.
- rst together with start: rst wins.

## Structure
- A shared package holds the state enumeration (S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR) and the MEM_CELL_SIZE=8 and INSTR_MEM_SIZE constants. These are the same values the instruction memory uses.
- No sub-module. The FSM, idx counter, checksum register and write register all live in one module of roughly 150–250 lines.
- Integration: the instruction memory gains a synchronous write port driven by mem_we, mem_addr and mem_wdata. The existing combinational read port is unchanged.

## Test plan
- **Normal load:** start, then 00 04 06 20 31 06 11 -> writes cells 0..3 = 06, 20, 31, 06; done=1, cpu_hold=0, error=0; fetch at address 0 returns 0x0620.
- **Bad checksum:** the same frame with CSUM 12 -> all 4 cells written, then error=1, cpu_hold=1, done=0; a following start and correct frame then reaches done=1.
- **Length errors:**
  - N=3 -> error one cycle after the LEN_LO accept, no mem_we, in_ready=0 afterwards.
  - N=MEM_SIZE+2 -> error.
  - N=MEM_SIZE -> last write at mem_addr = MEM_SIZE-1, then done.
- **Zero length:** N=0 with CSUM 00 -> done with no writes. N=0 with CSUM 01 -> error.
- **Backpressure and reset:** in_valid alternating 1/0 during the normal-load frame -> identical writes and result. Asserting rst after 2 payload accepts -> reset values on the next cycle, cpu_hold=1, cells 0..1 keep 06, 20; a following start and full frame succeeds.
- **Start while busy:** a start pulse during S_DATA -> ignored; idx and csum are undisturbed and the frame completes normally.
